seg_595_capture: RTL and testbench
==================================

# seg_595_capture

Receive-side counterpart of the 74HC595 seven-segment driver path. Samples the serial 595 pins (ds, shcp, stcp, oe) in the sys_clk domain, rebuilds each 14-bit sel/seg frame exactly as a 74HC595 pair would latch it, and decodes the latched segment pattern back into a per-digit value buffer. Used in loopback on the board and in system benches, where it checks what the display chain actually emits.

## Interface
- SYNC_STAGES, 2, synchronizer depth on ds/shcp/stcp/oe (min 2)
- sys_clk  in  1  system clock, 50 MHz
- sys_rst_n  in  1  synchronous, active-low reset
- ds  in  1  serial data pin
- shcp  in  1  shift clock pin; rising edge shifts ds
- stcp  in  1  storage clock pin; rising edge latches frame
- oe  in  1  output enable pin, active-low
- sel_q  out  6  latched digit select (one-hot, active-high)
- seg_q  out  8  latched segment byte (active-low, bit7 = dp)
- digits  out  24  4-bit code per digit, digit i at [4i+3:4i]
- dp  out  6  decimal point lit per digit
- minus  out  6  digit shows '-'
- blank  out  6  digit dark (seg_q[6:0] = 7'h7f)
- disp_on  out  1  synchronized ~oe
- frame_vld  out  1  one-cycle pulse per accepted frame
- err  out  1  one-cycle pulse per rejected frame

## Operation
- ds, shcp, stcp and oe each pass through SYNC_STAGES flops, plus one extra flop on shcp/stcp for edge detection. A rise is registered as cur=1, prev=0.
- shcp rise: shift the synchronized ds into sr[13:0]. bit_cnt increments and saturates at 15.
- Bit order on the wire: received bit k is sel[k] for k=0..5, then seg[13-k] for k=6..13. seg[0] arrives last.
- stcp rise: check the frame. bit_cnt==14, sel one-hot, and seg[6:0] a legal glyph means accept, else reject. bit_cnt clears to 0 in both cases.
- Accept: load sel_q/seg_q. For digit i = index of sel bit:
  - Write digits[i], then set dp[i]=~seg[7], minus[i]=(seg[6:0]==7'h3f), blank[i]=(seg[6:0]==7'h7f).
  - Pulse frame_vld.
  - Other digits hold their values.
- Reject: pulse err. sel_q, seg_q and the buffer hold.
- Legal glyphs (active-low, bit6=g..bit0=a) decode to hex codes 0–F:
  - 0–7: 40,79,24,30,19,12,02,78
  - 8–F: 00,10,08,03,46,21,06,0e
  - 3f ('-') and 7f (blank) also accept, and write code 0.
- disp_on only mirrors the pin. Capture continues while oe is high (595 latches are independent of oe).
- shcp and stcp rise in the same cycle: the latch uses the pre-shift sr and pre-increment bit_cnt. The shifted bit becomes bit 0 of the next frame, so bit_cnt = 1 afterwards.
- More than 14 shifts before stcp: bit_cnt saturates, and the frame is rejected.
- The 7-bit pattern is checked by the glyph lookup only. dp is independent of it.

## Timing
- Reset values:
  - sr, bit_cnt, sel_q all 0.
  - seg_q = 8'hff.
  - digits, dp, minus all 0.
  - blank = 6'h3f.
  - disp_on = 0.
  - frame_vld = 0, err = 0.
  - Synchronizers clear to 0, except oe, which clears to 1.
- Reset mid-frame discards the partial frame. No pulse is issued.
- The pin must hold ≥ 2 sys_clk high and ≥ 2 sys_clk low on shcp and stcp. The driver's 12.5 MHz shcp meets this.
- ds must be stable from the shcp rising edge until SYNC_STAGES sys_clk later.
- Latency, pin rise to shift: SYNC_STAGES+1 cycles (3 at default).
- Latency, stcp pin rise to sel_q/seg_q/buffer update and frame_vld/err pulse: SYNC_STAGES+2 cycles (4 at default).
- Every output is registered.

## Structure
- Package seg_595_pkg holds:
  - FRAME_BITS=14, SEL_W=6, SEG_W=8.
  - Glyph constants SEG_0..SEG_F, SEG_MINUS=8'hbf, SEG_BLANK=8'hff (shared with the driver-side segment encoder).
  - The glyph-to-code decode function.
- Sub-module hc595_deser contains the synchronizers, edge detect, sr, bit_cnt and the length check. It outputs sel_raw, seg_raw, a latch-strobe and len_ok.
- seg_595_capture holds the one-hot check, glyph decode and digit buffer.

## Test plan
- Single frame, sel=6'b000100, seg=8'hb0 ('3', dp off) -> frame_vld once. digits[11:8]=4'h3, dp[2]=0, blank[2]=0. Other digits unchanged.
- Full six-digit scan of 123456 with a dp on digit 3 (seg 8'h19 for digit 3) -> after six frames, digits=24'h654321, dp=6'b001000, blank=0.
- Send 13 bits then stcp; then 15 bits then stcp -> err pulses twice. No buffer change. Next valid 14-bit frame is accepted.
- sel=6'b000011, or seg=8'hff with sel valid -> err for the first, since sel is not one-hot. The second accepts with blank set. seg=8'h55 -> err.
- shcp and stcp rising together on the 15th edge -> frame of the first 14 bits accepted. bit_cnt=1 afterwards.
- sys_rst_n low after 7 bits -> no pulse. Outputs at reset values. A clean frame afterwards decodes correctly. oe toggled -> disp_on follows after SYNC_STAGES cycles.

Source files
------------

// File: rtl/seg_595_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_595_pkg
//  Brief    : Shared frame geometry, segment glyph constants and glyph decode
//             for the 74HC595 seven-segment capture path.
//  Revision : 1.0  initial release
// ============================================================================
package seg_595_pkg;

    localparam int FRAME_BITS  = 14;
    localparam int SEL_W       = 6;
    localparam int SEG_W       = 8;
    localparam int BIT_CNT_W   = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX  = 4'd15;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = 4'(FRAME_BITS);

    // Active-low segment bytes, bit7 = dp (off), bit6 = g .. bit0 = a
    localparam logic [SEG_W-1:0] SEG_0     = 8'hc0;
    localparam logic [SEG_W-1:0] SEG_1     = 8'hf9;
    localparam logic [SEG_W-1:0] SEG_2     = 8'ha4;
    localparam logic [SEG_W-1:0] SEG_3     = 8'hb0;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7     = 8'hf8;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
    localparam logic [SEG_W-1:0] SEG_A     = 8'h88;
    localparam logic [SEG_W-1:0] SEG_B     = 8'h83;
    localparam logic [SEG_W-1:0] SEG_C     = 8'hc6;
    localparam logic [SEG_W-1:0] SEG_D     = 8'ha1;
    localparam logic [SEG_W-1:0] SEG_E     = 8'h86;
    localparam logic [SEG_W-1:0] SEG_F     = 8'h8e;
    localparam logic [SEG_W-1:0] SEG_MINUS = 8'hbf;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hff;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } glyph_t;

    // Map a 7-bit segment pattern (dp excluded) back to its hex code.
    // '-' and blank are legal and carry code 0.
    function automatic glyph_t glyph_decode(input logic [6:0] pat);
        glyph_t g;
        g.valid = 1'b1;
        g.code  = 4'h0;
        case (pat)
            SEG_0[6:0]:     g.code = 4'h0;
            SEG_1[6:0]:     g.code = 4'h1;
            SEG_2[6:0]:     g.code = 4'h2;
            SEG_3[6:0]:     g.code = 4'h3;
            SEG_4[6:0]:     g.code = 4'h4;
            SEG_5[6:0]:     g.code = 4'h5;
            SEG_6[6:0]:     g.code = 4'h6;
            SEG_7[6:0]:     g.code = 4'h7;
            SEG_8[6:0]:     g.code = 4'h8;
            SEG_9[6:0]:     g.code = 4'h9;
            SEG_A[6:0]:     g.code = 4'ha;
            SEG_B[6:0]:     g.code = 4'hb;
            SEG_C[6:0]:     g.code = 4'hc;
            SEG_D[6:0]:     g.code = 4'hd;
            SEG_E[6:0]:     g.code = 4'he;
            SEG_F[6:0]:     g.code = 4'hf;
            SEG_MINUS[6:0]: g.code = 4'h0;
            SEG_BLANK[6:0]: g.code = 4'h0;
            default:        g.valid = 1'b0;
        endcase
        return g;
    endfunction

    function automatic logic is_onehot(input logic [SEL_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hc595_deser.sv
`default_nettype none
// ============================================================================
//  Module   : hc595_deser
//  Brief    : Pin synchronizers, shcp/stcp rise detection, 14-bit shift
//             register and frame-length check of a 74HC595 pair receiver.
//  Revision : 1.0  initial release
// ============================================================================
module hc595_deser
    import seg_595_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             ds,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             oe,
    output logic [SEL_W-1:0] sel_raw,
    output logic [SEG_W-1:0] seg_raw,
    output logic             latch_stb,
    output logic             len_ok,
    output logic             disp_on
);

    logic [SYNC_STAGES-1:0] ds_sync_q, shcp_sync_q, stcp_sync_q;
    logic                   shcp_prev_q, stcp_prev_q;
    // oe chain is one stage short; disp_on_q is its final (inverting) stage
    logic [SYNC_STAGES-2:0] oe_sync_q, oe_sync_d;
    logic                   disp_on_q;

    logic [FRAME_BITS-1:0]  sr_q, sr_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SEL_W-1:0]       sel_raw_q, sel_raw_d;
    logic [SEG_W-1:0]       seg_raw_q, seg_raw_d;
    logic                   latch_stb_q, latch_stb_d;
    logic                   len_ok_q, len_ok_d;

    logic                   shcp_rise, stcp_rise, ds_s;

    assign shcp_rise = shcp_sync_q[SYNC_STAGES-1] & ~shcp_prev_q;
    assign stcp_rise = stcp_sync_q[SYNC_STAGES-1] & ~stcp_prev_q;
    assign ds_s      = ds_sync_q[SYNC_STAGES-1];

    // Next value of the oe chain (written as a loop so depth 2 needs no slice)
    always_comb begin
        oe_sync_d = oe_sync_q;
        for (int i = SYNC_STAGES - 2; i > 0; i--) begin
            oe_sync_d[i] = oe_sync_q[i-1];
        end
        oe_sync_d[0] = oe;
    end

    // Pin synchronizers plus the extra edge-detect flop on shcp/stcp
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            ds_sync_q   <= '0;
            shcp_sync_q <= '0;
            stcp_sync_q <= '0;
            shcp_prev_q <= 1'b0;
            stcp_prev_q <= 1'b0;
            oe_sync_q   <= '1;
            disp_on_q   <= 1'b0;
        end else begin
            ds_sync_q   <= {ds_sync_q[SYNC_STAGES-2:0], ds};
            shcp_sync_q <= {shcp_sync_q[SYNC_STAGES-2:0], shcp};
            stcp_sync_q <= {stcp_sync_q[SYNC_STAGES-2:0], stcp};
            shcp_prev_q <= shcp_sync_q[SYNC_STAGES-1];
            stcp_prev_q <= stcp_sync_q[SYNC_STAGES-1];
            oe_sync_q   <= oe_sync_d;
            disp_on_q   <= ~oe_sync_q[SYNC_STAGES-2];
        end
    end

    // Shift/latch next-state: a latch always sees the pre-shift frame, and a
    // coincident shift starts the following frame at one bit
    always_comb begin
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        sel_raw_d   = sel_raw_q;
        seg_raw_d   = seg_raw_q;
        len_ok_d    = len_ok_q;
        latch_stb_d = 1'b0;
        if (stcp_rise) begin
            latch_stb_d = 1'b1;
            len_ok_d    = (bit_cnt_q == BIT_CNT_FULL);
            // first wire bit lands in sr[13] and is sel[0]
            for (int k = 0; k < SEL_W; k++) begin
                sel_raw_d[k] = sr_q[FRAME_BITS-1-k];
            end
            seg_raw_d   = sr_q[SEG_W-1:0];
            bit_cnt_d   = '0;
        end
        if (shcp_rise) begin
            sr_d = {sr_q[FRAME_BITS-2:0], ds_s};
            if (stcp_rise) begin
                bit_cnt_d = 4'd1;
            end else if (bit_cnt_q != BIT_CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    // Shift register, bit counter and latch snapshot registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            sel_raw_q   <= '0;
            seg_raw_q   <= SEG_BLANK;
            latch_stb_q <= 1'b0;
            len_ok_q    <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            sel_raw_q   <= sel_raw_d;
            seg_raw_q   <= seg_raw_d;
            latch_stb_q <= latch_stb_d;
            len_ok_q    <= len_ok_d;
        end
    end

    assign sel_raw   = sel_raw_q;
    assign seg_raw   = seg_raw_q;
    assign latch_stb = latch_stb_q;
    assign len_ok    = len_ok_q;
    assign disp_on   = disp_on_q;

endmodule
`default_nettype wire

// File: rtl/seg_595_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg_595_capture
//  Brief    : Rebuilds 74HC595 sel/seg frames from the serial pins, validates
//             them and decodes the segment pattern into a per-digit buffer.
//  Revision : 1.0  initial release
// ============================================================================
module seg_595_capture
    import seg_595_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 ds,
    input  logic                 shcp,
    input  logic                 stcp,
    input  logic                 oe,
    output logic [SEL_W-1:0]     sel_q,
    output logic [SEG_W-1:0]     seg_q,
    output logic [4*SEL_W-1:0]   digits,
    output logic [SEL_W-1:0]     dp,
    output logic [SEL_W-1:0]     minus,
    output logic [SEL_W-1:0]     blank,
    output logic                 disp_on,
    output logic                 frame_vld,
    output logic                 err
);

    logic [SEL_W-1:0]   sel_raw;
    logic [SEG_W-1:0]   seg_raw;
    logic               latch_stb, len_ok;

    hc595_deser #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ds        (ds),
        .shcp      (shcp),
        .stcp      (stcp),
        .oe        (oe),
        .sel_raw   (sel_raw),
        .seg_raw   (seg_raw),
        .latch_stb (latch_stb),
        .len_ok    (len_ok),
        .disp_on   (disp_on)
    );

    logic [SEL_W-1:0]   sel_lat_q, sel_lat_d;
    logic [SEG_W-1:0]   seg_lat_q, seg_lat_d;
    logic [4*SEL_W-1:0] digits_q, digits_d;
    logic [SEL_W-1:0]   dp_q, dp_d, minus_q, minus_d, blank_q, blank_d;
    logic               frame_vld_q, frame_vld_d, err_q, err_d;
    glyph_t             glyph;
    logic               accept;

    // Frame check and digit-buffer update; only the selected digit changes
    always_comb begin
        glyph       = glyph_decode(seg_raw[6:0]);
        accept      = latch_stb & len_ok & is_onehot(sel_raw) & glyph.valid;
        frame_vld_d = accept;
        err_d       = latch_stb & ~accept;
        sel_lat_d   = sel_lat_q;
        seg_lat_d   = seg_lat_q;
        digits_d    = digits_q;
        dp_d        = dp_q;
        minus_d     = minus_q;
        blank_d     = blank_q;
        if (accept) begin
            sel_lat_d = sel_raw;
            seg_lat_d = seg_raw;
            for (int i = 0; i < SEL_W; i++) begin
                if (sel_raw[i]) begin
                    digits_d[4*i +: 4] = glyph.code;
                    dp_d[i]    = ~seg_raw[7];
                    minus_d[i] = (seg_raw[6:0] == SEG_MINUS[6:0]);
                    blank_d[i] = (seg_raw[6:0] == SEG_BLANK[6:0]);
                end
            end
        end
    end

    // Latched frame, digit buffer and status pulses
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel_lat_q   <= '0;
            seg_lat_q   <= SEG_BLANK;
            digits_q    <= '0;
            dp_q        <= '0;
            minus_q     <= '0;
            blank_q     <= '1;
            frame_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sel_lat_q   <= sel_lat_d;
            seg_lat_q   <= seg_lat_d;
            digits_q    <= digits_d;
            dp_q        <= dp_d;
            minus_q     <= minus_d;
            blank_q     <= blank_d;
            frame_vld_q <= frame_vld_d;
            err_q       <= err_d;
        end
    end

    assign sel_q     = sel_lat_q;
    assign seg_q     = seg_lat_q;
    assign digits    = digits_q;
    assign dp        = dp_q;
    assign minus     = minus_q;
    assign blank     = blank_q;
    assign frame_vld = frame_vld_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_595_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_595_capture
//  Brief    : Self-checking bench for seg_595_capture: drives the serial 595
//             pins and compares against a frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_595_capture;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b1;
    logic [5:0]  sel_q, dp, minus, blank;
    logic [7:0]  seg_q;
    logic [23:0] digits;
    logic        disp_on, frame_vld, err;

    seg_595_capture #(.SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .ds        (ds),
        .shcp      (shcp),
        .stcp      (stcp),
        .oe        (oe),
        .sel_q     (sel_q),
        .seg_q     (seg_q),
        .digits    (digits),
        .dp        (dp),
        .minus     (minus),
        .blank     (blank),
        .disp_on   (disp_on),
        .frame_vld (frame_vld),
        .err       (err)
    );

    always #10 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // reference model: display state as seen by a viewer, plus the bits sent
    logic [3:0] m_dig   [6];
    logic       m_dp    [6];
    logic       m_minus [6];
    logic       m_blank [6];
    logic [5:0] m_sel;
    logic [7:0] m_seg;
    logic       m_disp;
    bit         q[$];
    int         exp_vld = 0, exp_err = 0, mon_vld = 0, mon_err = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

    always @(negedge sys_clk) begin
        if (frame_vld === 1'b1) mon_vld++;
        if (err === 1'b1)       mon_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) begin
            m_dig[i] = 4'h0; m_dp[i] = 1'b0; m_minus[i] = 1'b0; m_blank[i] = 1'b1;
        end
        m_sel = 6'h00;
        m_seg = 8'hff;
        q.delete();
    endfunction

    function automatic int glyph_code(input logic [6:0] p);
        if (p == 7'h3f || p == 7'h7f) return 0;
        for (int c = 0; c < 16; c++) if (glyph_tab[c] == p) return c;
        return -1;
    endfunction

    function automatic logic [23:0] m_digits();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) v[4*i +: 4] = m_dig[i];
        return v;
    endfunction

    function automatic logic [5:0] m_vec(input int which);
        logic [5:0] v;
        for (int i = 0; i < 6; i++)
            v[i] = (which == 0) ? m_dp[i] : (which == 1) ? m_minus[i] : m_blank[i];
        return v;
    endfunction

    // what a 595 pair would show after storage clock with the bits in q
    function automatic bit model_latch();
        logic [5:0] s;
        logic [7:0] g;
        int         code, idx;
        bit         acc;
        acc = 1'b0;
        if (q.size() == 14) begin
            for (int k = 0; k < 6; k++)  s[k]      = q[k];
            for (int k = 6; k < 14; k++) g[13 - k] = q[k];
            code = glyph_code(g[6:0]);
            if ($countones(s) == 1 && code >= 0) begin
                acc = 1'b1;
                idx = 0;
                for (int i = 0; i < 6; i++) if (s[i]) idx = i;
                m_dig[idx]   = 4'(code);
                m_dp[idx]    = ~g[7];
                m_minus[idx] = (g[6:0] == 7'h3f);
                m_blank[idx] = (g[6:0] == 7'h7f);
                m_sel = s;
                m_seg = g;
            end
        end
        q.delete();
        if (acc) exp_vld++; else exp_err++;
        return acc;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".sel"},    32'(sel_q),      32'(m_sel));
        check({tag, ".seg"},    32'(seg_q),      32'(m_seg));
        check({tag, ".digits"}, 32'(digits),     32'(m_digits()));
        check({tag, ".dp"},     32'(dp),         32'(m_vec(0)));
        check({tag, ".minus"},  32'(minus),      32'(m_vec(1)));
        check({tag, ".blank"},  32'(blank),      32'(m_vec(2)));
        check({tag, ".disp"},   32'(disp_on),    32'(m_disp));
    endtask

    task automatic send_bit(input bit b);
        ds = b; shcp = 1'b0;
        tick(2);
        shcp = 1'b1;
        q.push_back(b);
        tick(2);
    endtask

    task automatic send_frame(input logic [5:0] s, input logic [7:0] g, input int first, input int nbits);
        bit b;
        for (int k = first; k < nbits; k++) begin
            if (k < 6)       b = s[k];
            else if (k < 14) b = g[13 - k];
            else             b = bit'($urandom_range(0, 1));
            send_bit(b);
        end
    endtask

    // storage clock pulse, optionally with a coincident shift clock of bit b;
    // checks the pulse appears exactly 4 cycles after the pin rise
    task automatic do_latch(input string tag, input bit with_bit, input bit b);
        bit acc;
        stcp = 1'b0; shcp = 1'b0;
        if (with_bit) ds = b;
        tick(2);
        acc = model_latch();
        if (with_bit) q.push_back(b);
        stcp = 1'b1;
        if (with_bit) shcp = 1'b1;
        tick(2);
        stcp = 1'b0; shcp = 1'b0;
        tick(1);
        check({tag, ".early"}, 32'({frame_vld, err}), 32'(2'b00));
        tick(1);
        check({tag, ".pulse"}, 32'({frame_vld, err}), 32'({acc, ~acc}));
        tick(1);
        check({tag, ".once"},  32'({frame_vld, err}), 32'(2'b00));
        check_all(tag);
    endtask

    initial begin
        logic [5:0] s;
        logic [7:0] g;
        int         r, nb;

        model_reset();
        m_disp = 1'b0;
        tick(5);
        check_all("reset");
        check("reset.vld", 32'(frame_vld), 32'd0);
        check("reset.err", 32'(err), 32'd0);
        sys_rst_n = 1'b1;
        tick(3);

        // single '3' on digit 2, dp off
        send_frame(6'b000100, 8'hb0, 0, 14);
        do_latch("one", 1'b0, 1'b0);
        check("one.d2",  32'(digits[11:8]), 32'h3);
        check("one.dp2", 32'(dp[2]), 32'd0);
        check("one.bl2", 32'(blank[2]), 32'd0);

        // six-digit scan of 123456, dp on digit 3
        send_frame(6'b000001, 8'hf9, 0, 14); do_latch("scan0", 1'b0, 1'b0);
        send_frame(6'b000010, 8'ha4, 0, 14); do_latch("scan1", 1'b0, 1'b0);
        send_frame(6'b000100, 8'hb0, 0, 14); do_latch("scan2", 1'b0, 1'b0);
        send_frame(6'b001000, 8'h19, 0, 14); do_latch("scan3", 1'b0, 1'b0);
        send_frame(6'b010000, 8'h92, 0, 14); do_latch("scan4", 1'b0, 1'b0);
        send_frame(6'b100000, 8'h82, 0, 14); do_latch("scan5", 1'b0, 1'b0);
        check("scan.digits", 32'(digits), 32'h654321);
        check("scan.dp",     32'(dp),     32'(6'b001000));
        check("scan.blank",  32'(blank),  32'd0);

        // short and long frames are rejected, then a good one is accepted
        send_frame(6'b000001, 8'h92, 0, 13); do_latch("short", 1'b0, 1'b0);
        send_frame(6'b000001, 8'h92, 0, 15); do_latch("long",  1'b0, 1'b0);
        send_frame(6'b000001, 8'h99, 0, 14); do_latch("after", 1'b0, 1'b0);

        // sel not one-hot, blank glyph, illegal glyph
        send_frame(6'b000011, 8'hc0, 0, 14); do_latch("twohot", 1'b0, 1'b0);
        send_frame(6'b010000, 8'hff, 0, 14); do_latch("blankg", 1'b0, 1'b0);
        send_frame(6'b000010, 8'h55, 0, 14); do_latch("badg",   1'b0, 1'b0);
        send_frame(6'b000100, 8'hbf, 0, 14); do_latch("minusg", 1'b0, 1'b0);

        // storage clock coincides with the 15th shift; that bit starts the next frame
        send_frame(6'b000010, 8'h86, 0, 14);
        s = 6'b010000; g = 8'h08;
        do_latch("same", 1'b1, s[0]);
        send_frame(s, g, 1, 14);
        do_latch("same.next", 1'b0, 1'b0);

        // reset in the middle of a frame
        send_frame(6'b000001, 8'hc6, 0, 7);
        shcp = 1'b0;
        tick(1);
        sys_rst_n = 1'b0;
        tick(4);
        sys_rst_n = 1'b1;
        model_reset();
        tick(2);
        check_all("midrst");
        check("midrst.pulse", 32'({frame_vld, err}), 32'(2'b00));
        send_frame(6'b001000, 8'ha1, 0, 14); do_latch("postrst", 1'b0, 1'b0);

        // oe follows after two cycles
        oe = 1'b0;
        tick(1); check("oe.lo1", 32'(disp_on), 32'd0);
        tick(1); check("oe.lo2", 32'(disp_on), 32'd1);
        oe = 1'b1;
        tick(1); check("oe.hi1", 32'(disp_on), 32'd1);
        tick(1); check("oe.hi2", 32'(disp_on), 32'd0);
        oe = 1'b0;
        m_disp = 1'b1;
        tick(3);

        // randomized frames
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) s = 6'($urandom);
            else        s = 6'b000001 << $urandom_range(0, 5);
            r = int'($urandom_range(0, 19));
            if (r < 16)       g = {1'($urandom), glyph_tab[r]};
            else if (r == 16) g = {1'($urandom), 7'h3f};
            else if (r == 17) g = {1'($urandom), 7'h7f};
            else              g = 8'($urandom);
            r = int'($urandom_range(0, 9));
            nb = (r == 0) ? 13 : (r == 1) ? int'($urandom_range(15, 17)) : 14;
            send_frame(s, g, 0, nb);
            do_latch($sformatf("rnd%0d", it), 1'b0, 1'b0);
        end

        tick(4);
        check("total.vld", 32'(mon_vld), 32'(exp_vld));
        check("total.err", 32'(mon_err), 32'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
